uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one 8N1 UART transmitter between N_REQ requesters.
- Accepts one byte at a time from the winning requester and issues it to the transmitter as a single-cycle valid pulse.
- Waits for the transmitter's completion pulse, then returns to arbitration. Includes a post-reset flush window and a watchdog timeout.
- Sits between on-chip message sources (status, debug, response paths) and the UART transmitter's i_data/i_valid/o_valid ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- NB_DATA, 8, byte width; must match the transmitter's NB_DATA_IN.
- FRAME_CYCLES, 870, clock cycles per frame (10 bits x 87 cycles/bit).
- TIMEOUT_CYCLES, 1024, WAIT_DONE watchdog limit; must exceed FRAME_CYCLES.

Ports:
- clock, in, 1, system clock; all logic on rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_enable, in, 1, permits new grants; an in-flight frame always completes.
- i_req_valid, in, N_REQ, per-requester request; held with data stable until ready.
- i_req_data, in, N_REQ*NB_DATA, requester k byte at [k*NB_DATA +: NB_DATA].
- o_req_ready, out, N_REQ, one-hot single-cycle acceptance pulse.
- o_tx_data, out, NB_DATA, byte to the transmitter.
- o_tx_valid, out, 1, single-cycle issue pulse to the transmitter.
- i_tx_done, in, 1, transmitter completion flag (high 2 cycles at frame end).
- o_grant_id, out, $clog2(N_REQ), index of last granted requester.
- o_busy, out, 1, high in every state except IDLE.
- o_timeout, out, 1, single-cycle pulse on watchdog expiry.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync use after deassert):
  - state=FLUSH, counter=0, o_req_ready=0, o_tx_valid=0, o_tx_data=0, o_grant_id=N_REQ-1, o_busy=1, o_timeout=0.
  - The rr pointer holds the last grant, so requester 0 has top priority first.
- The transmitter has no reset. FLUSH therefore lets any frame in progress drain before the first issue.
- States:
  - FLUSH: count to FRAME_CYCLES+2, then go to IDLE.
  - IDLE: if i_enable and any i_req_valid, pick winner w = first set bit searching from o_grant_id+1 upward, wrapping modulo N_REQ. On that edge: o_tx_data<=i_req_data[w], o_tx_valid<=1, o_req_ready[w]<=1, o_grant_id<=w, counter<=0, go to WAIT_DONE.
  - WAIT_DONE: o_tx_valid and o_req_ready return to 0 after exactly one cycle. Counter increments each cycle. If i_tx_done=1, go to GAP. Otherwise, when counter reaches TIMEOUT_CYCLES-1, pulse o_timeout and go to GAP.
  - GAP: stay while i_tx_done=1; go to IDLE on the first cycle it is 0. Minimum 1 cycle.
- Issue latency:
  - Request present in IDLE at cycle t: o_tx_valid and o_req_ready high in cycle t+1.
  - Earliest next issue is cycle d+2, where d is the first cycle i_tx_done is 0 after completion.
  - o_tx_valid is never asserted while i_tx_done=1.
- Requester contract:
  - Drop or replace i_req_valid/data in the cycle after the ready pulse.
  - The arbiter does not sample requests outside IDLE, so a stale valid in cycle t+2 is harmless.
- Simultaneous requests: strict rotation; no requester is granted twice while another requester is waiting.
- i_enable low in IDLE: no grant, state holds. Deasserting i_enable mid-frame has no effect until IDLE.
- i_tx_done pulse while in IDLE or FLUSH: ignored.
- Timeout: the byte is counted as consumed; there is no retry.
- Reset mid-frame: the outputs and state above take effect immediately; the granted byte is lost.

Test Plan:
- Single request: after FLUSH, req1 data 0xA5 → o_tx_valid and o_req_ready=4'b0010 one cycle later; o_tx_data=0xA5; o_grant_id=1; line decodes 0xA5.
- Contention: all 4 requesting from reset (data 0x10,0x11,0x12,0x13) → issued in order 0,1,2,3, one frame each, no overlap with i_tx_done high.
- Fairness: req0 and req2 held continuously → grants alternate 0,2,0,2 for 6 frames.
- Timeout: transmitter model with i_tx_done stuck 0 → o_timeout pulses exactly TIMEOUT_CYCLES cycles after issue; next request is issued after GAP.
- Enable: i_enable=0 with req3 pending → no o_tx_valid for 2000 cycles; i_enable=1 → issue next cycle+1.
- Reset mid-frame: i_rst_n low during WAIT_DONE → outputs at reset values asynchronously; no o_tx_valid for FRAME_CYCLES+2 cycles after release; requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The arbiter uses the slave modport. The requesters and transmitter use master.
interface uart_tx_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int NB_DATA = 8
);
  localparam int GID_W = $clog2(N_REQ);

  logic                     i_enable;
  logic [N_REQ-1:0]         i_req_valid;
  logic [N_REQ*NB_DATA-1:0] i_req_data;
  logic [N_REQ-1:0]         o_req_ready;
  logic [NB_DATA-1:0]       o_tx_data;
  logic                     o_tx_valid;
  logic                     i_tx_done;
  logic [GID_W-1:0]         o_grant_id;
  logic                     o_busy;
  logic                     o_timeout;

  modport slave (
    input  i_enable, i_req_valid, i_req_data, i_tx_done,
    output o_req_ready, o_tx_data, o_tx_valid, o_grant_id, o_busy, o_timeout
  );

  modport master (
    output i_enable, i_req_valid, i_req_data, i_tx_done,
    input  o_req_ready, o_tx_data, o_tx_valid, o_grant_id, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter between N_REQ byte sources.
// A post-reset flush lets the transmitter drain any frame in progress, because the transmitter has no reset.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int NB_DATA        = 8,
  parameter int FRAME_CYCLES   = 870,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             i_rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int GID_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (FRAME_CYCLES + 1 > TIMEOUT_CYCLES - 1) ? FRAME_CYCLES + 1
                                                                   : TIMEOUT_CYCLES - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [NB_DATA-1:0] req_data_arr [N_REQ];
  logic               win_found;
  logic [GID_W-1:0]   win_idx;
  logic [GID_W-1:0]   scan_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_data_arr[gi] = bus.i_req_data[gi*NB_DATA +: NB_DATA];
  end

  // Scan from the farthest slot down to the nearest, so the nearest requester after the last grant wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      scan_idx = GID_W'((int'(grant_id_q) + i) % N_REQ);
      if (bus.i_req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    grant_id_d  = grant_id_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.i_enable && win_found) begin
          state_d     = S_WAIT_DONE;
          cnt_d       = '0;
          tx_data_d   = req_data_arr[win_idx];
          tx_valid_d  = 1'b1;
          req_ready_d = N_REQ'(1) << win_idx;
          grant_id_d  = win_idx;
        end
      end
      S_WAIT_DONE: begin
        if (bus.i_tx_done) begin
          state_d = S_GAP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        // Hold off until the done pulse has ended, so a new issue never overlaps it.
        if (!bus.i_tx_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_FLUSH;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_FLUSH;
      cnt_q       <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      grant_id_q  <= GID_W'(N_REQ - 1);
      busy_q      <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_valid  = tx_valid_q;
  assign bus.o_grant_id  = grant_id_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_timeout   = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner-case sequences and a randomized queue model.
// A behavioural transmitter raises done for the last two cycles of each frame and flags any overlapping issue.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N_REQ          = 4;
  localparam int NB_DATA        = 8;
  localparam int FRAME_CYCLES   = 40;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int BUDGET         = FRAME_CYCLES + 20;

  logic clock   = 1'b0;
  logic i_rst_n = 1'b0;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .NB_DATA(NB_DATA)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .NB_DATA(NB_DATA),
    .FRAME_CYCLES(FRAME_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .i_rst_n(i_rst_n),
    .bus(bus)
  );

  // Transmitter model: no reset; a stuck transmitter never raises done.
  bit         tx_stuck      = 1'b0;
  bit         tx_busy       = 1'b0;
  int         tx_k          = 0;
  int         tx_violations = 0;
  logic [7:0] tx_last_byte  = 8'h00;

  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (bus.o_tx_valid) begin
        if (tx_busy || bus.i_tx_done) tx_violations++;
        tx_last_byte  = bus.o_tx_data;
        tx_busy       = !tx_stuck;
        tx_k          = 0;
        bus.i_tx_done = 1'b0;
      end else if (tx_busy) begin
        tx_k++;
        bus.i_tx_done = (tx_k >= FRAME_CYCLES - 1);
        if (tx_k == FRAME_CYCLES) tx_busy = 1'b0;
      end else begin
        bus.i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_issue(input int budget, output bit seen, output int at);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.o_tx_valid) begin
        seen = 1'b1;
        at   = cyc;
        $display("issue cyc=%0d id=%0d data=0x%02h ready=%b", cyc, bus.o_grant_id,
                 bus.o_tx_data, bus.o_req_ready);
        return;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!bus.o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_reach_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic check_grant(input string name, input int id, input logic [7:0] data);
    check({name, "_id"}, 32'(bus.o_grant_id), 32'(id));
    check({name, "_data"}, 32'(bus.o_tx_data), 32'(data));
    check({name, "_ready"}, 32'(bus.o_req_ready), 32'(1) << id);
  endtask

  typedef struct {
    logic [N_REQ-1:0]         valid;
    logic [N_REQ*NB_DATA-1:0] data;
    logic                     en;
    int                       exp_id;
    logic [NB_DATA-1:0]       exp_data;
  } vec_t;

  vec_t vecs[9];

  logic [7:0] rq [N_REQ][$];

  task automatic drive_from_queues();
    for (int k = 0; k < N_REQ; k++) begin
      bus.i_req_valid[k] = (rq[k].size() > 0);
      bus.i_req_data[k*NB_DATA +: NB_DATA] = (rq[k].size() > 0) ? rq[k][0] : 8'h00;
    end
  endtask

  initial begin
    bit   seen;
    int   at, at2, t_to, rel, nvalid, model_last, exp_id, total;
    logic [7:0] exp_byte;

    // Vector sequence starts right after reset, so the last grant is N_REQ-1.
    vecs[0] = '{4'b0010, 32'h0000_A500, 1'b1, 1, 8'hA5};
    vecs[1] = '{4'b1111, 32'h1312_1110, 1'b1, 2, 8'h12};
    vecs[2] = '{4'b1111, 32'h1312_1110, 1'b1, 3, 8'h13};
    vecs[3] = '{4'b1111, 32'h1312_1110, 1'b1, 0, 8'h10};
    vecs[4] = '{4'b0101, 32'h00C3_003C, 1'b1, 2, 8'hC3};
    vecs[5] = '{4'b0101, 32'h00C3_003C, 1'b1, 0, 8'h3C};
    vecs[6] = '{4'b1001, 32'h7E00_00E7, 1'b0, -1, 8'h00};
    vecs[7] = '{4'b1001, 32'h7E00_00E7, 1'b1, 3, 8'h7E};
    vecs[8] = '{4'b0001, 32'h0000_00E7, 1'b1, 0, 8'hE7};

    bus.i_enable    = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    i_rst_n         = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    check("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
    check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_grant_id", 32'(bus.o_grant_id), 32'(N_REQ - 1));
    check("rst_busy", 32'(bus.o_busy), 32'd1);
    check("rst_timeout", 32'(bus.o_timeout), 32'd0);
    i_rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      wait_idle($sformatf("vec%0d", v), BUDGET + FRAME_CYCLES);
      bus.i_req_valid = vecs[v].valid;
      bus.i_req_data  = vecs[v].data;
      bus.i_enable    = vecs[v].en;
      if (vecs[v].exp_id < 0) begin
        wait_issue(50, seen, at);
        check($sformatf("vec%0d_no_issue", v), 32'(seen), 32'd0);
        check($sformatf("vec%0d_idle_hold", v), 32'(bus.o_busy), 32'd0);
      end else begin
        wait_issue(1, seen, at);
        check($sformatf("vec%0d_latency", v), 32'(seen), 32'd1);
        if (seen) check_grant($sformatf("vec%0d", v), vecs[v].exp_id, vecs[v].exp_data);
        bus.i_req_valid = '0;
        wait_idle($sformatf("vec%0d_done", v), BUDGET);
        check($sformatf("vec%0d_line_byte", v), 32'(tx_last_byte), 32'(vecs[v].exp_data));
      end
      bus.i_req_valid = '0;
    end

    // Fairness: requesters 0 and 2 held continuously after a grant to 0.
    bus.i_enable    = 1'b1;
    bus.i_req_valid = 4'b0101;
    bus.i_req_data  = 32'h0022_0011;
    for (int n = 0; n < 6; n++) begin
      exp_id = (n % 2 == 0) ? 2 : 0;
      wait_issue(BUDGET, seen, at);
      check($sformatf("fair%0d_seen", n), 32'(seen), 32'd1);
      if (seen) check_grant($sformatf("fair%0d", n), exp_id, (exp_id == 2) ? 8'h22 : 8'h11);
    end
    bus.i_req_valid = '0;

    // Watchdog: done never arrives.
    wait_idle("to_pre", BUDGET);
    tx_stuck        = 1'b1;
    bus.i_req_valid = 4'b0010;
    bus.i_req_data  = 32'h0000_5A00;
    wait_issue(1, seen, at);
    check("to_issue_seen", 32'(seen), 32'd1);
    if (seen) check_grant("to_issue", 1, 8'h5A);
    bus.i_req_valid = '0;
    t_to = -1;
    for (int i = 0; i < TIMEOUT_CYCLES + 10; i++) begin
      tick();
      if (bus.o_timeout) begin
        t_to = cyc;
        break;
      end
    end
    check("to_delay", 32'(t_to - at), 32'(TIMEOUT_CYCLES));
    tx_stuck        = 1'b0;
    bus.i_req_valid = 4'b0100;
    bus.i_req_data  = 32'h006B_0000;
    tick();
    check("to_pulse_width", 32'(bus.o_timeout), 32'd0);
    wait_issue(1, seen, at2);
    check("to_next_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_grant("to_next", 2, 8'h6B);
      check("to_next_gap", 32'(at2 - t_to), 32'd2);
    end
    bus.i_req_valid = '0;

    // Enable gating, then a mid-frame disable that must not stall the frame.
    wait_idle("en_pre", BUDGET);
    bus.i_enable    = 1'b0;
    bus.i_req_valid = 4'b1000;
    bus.i_req_data  = 32'h9900_0000;
    nvalid = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bus.o_tx_valid) nvalid++;
    end
    check("en_off_no_issue", 32'(nvalid), 32'd0);
    check("en_off_idle", 32'(bus.o_busy), 32'd0);
    bus.i_enable = 1'b1;
    wait_issue(1, seen, at);
    check("en_on_latency", 32'(seen), 32'd1);
    if (seen) check_grant("en_on", 3, 8'h99);
    bus.i_req_valid = '0;
    bus.i_enable    = 1'b0;
    wait_idle("en_midframe", BUDGET);
    check("en_line_byte", 32'(tx_last_byte), 32'h99);
    bus.i_enable = 1'b1;

    // Reset during WAIT_DONE, then contention from reset.
    wait_idle("rst_pre", BUDGET);
    bus.i_req_valid = 4'b0100;
    bus.i_req_data  = 32'h1312_1110;
    wait_issue(1, seen, at);
    check("rst_pre_seen", 32'(seen), 32'd1);
    if (seen) check_grant("rst_pre", 2, 8'h12);
    bus.i_req_valid = 4'b1111;
    repeat (10) tick();
    i_rst_n = 1'b0;
    #1;
    check("arst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("arst_grant_id", 32'(bus.o_grant_id), 32'(N_REQ - 1));
    check("arst_busy", 32'(bus.o_busy), 32'd1);
    check("arst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    rel = cyc;
    for (int n = 0; n < N_REQ; n++) begin
      wait_issue(BUDGET, seen, at);
      check($sformatf("cont%0d_seen", n), 32'(seen), 32'd1);
      if (seen) begin
        if (n == 0) begin
          checks++;
          if (at - rel < FRAME_CYCLES + 3 || at - rel > FRAME_CYCLES + 4) begin
            errors++;
            $display("FAIL flush_len: first issue %0d cycles after release, expected %0d..%0d",
                     at - rel, FRAME_CYCLES + 3, FRAME_CYCLES + 4);
          end
        end
        check_grant($sformatf("cont%0d", n), n, 8'(8'h10 + n));
      end
      bus.i_req_valid[n] = 1'b0;
    end

    // Randomized: per-requester byte queues against a rotate-from-last-grant model.
    model_last = N_REQ - 1;
    for (int r = 0; r < 3; r++) begin
      wait_idle($sformatf("rnd%0d_pre", r), BUDGET);
      total = 0;
      for (int k = 0; k < N_REQ; k++) begin
        int cnt = $urandom_range(0, 4);
        for (int j = 0; j < cnt; j++) rq[k].push_back(8'($urandom_range(0, 255)));
        total += cnt;
      end
      drive_from_queues();
      while (total > 0) begin
        exp_id = -1;
        for (int s = N_REQ; s >= 1; s--)
          if (rq[(model_last + s) % N_REQ].size() > 0) exp_id = (model_last + s) % N_REQ;
        exp_byte = rq[exp_id][0];
        wait_issue(BUDGET, seen, at);
        check($sformatf("rnd%0d_seen", r), 32'(seen), 32'd1);
        if (!seen) break;
        check_grant($sformatf("rnd%0d", r), exp_id, exp_byte);
        void'(rq[exp_id].pop_front());
        model_last = exp_id;
        total--;
        drive_from_queues();
      end
      for (int k = 0; k < N_REQ; k++) rq[k].delete();
      bus.i_req_valid = '0;
    end

    wait_idle("final", BUDGET);
    check("tx_overlap_violations", 32'(tx_violations), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
